output_post_data_module: RTL

OUTPUT_POST_DATA_MODULE -- requirements
Module: output_post_data_module

---
 rtl/output_post_data_module.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/output_post_data_module.sv
// Ping-pong frame buffer that accepts wide parallel frames and serialises them
// byte by byte, optionally dropping a number of leading and trailing bytes.
// Two banks let the next frame be loaded while the current one drains, so
// back-to-back frames stream out with no idle cycle between them.
module output_post_data_module #(
    parameter int unsigned NUM_BYTES = 34,
    parameter int unsigned DW        = 8
) (
    input  logic                      dout_clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [0:NUM_BYTES*DW-1]   parallel_data,
    input  logic                      i_parallel_vld,
    output logic                      o_parallel_rdy,
    input  logic [5:0]                i_strip_head,
    input  logic [5:0]                i_strip_tail,
    output logic [DW-1:0]             o_data_dout,
    output logic                      o_data_dout_vld,
    input  logic                      i_data_dout_rdy,
    output logic                      o_frame_last,
    output logic                      o_busy
);

    localparam int unsigned FW = NUM_BYTES * DW;
    // Wide enough for head + tail (each up to 63) and for any byte index.
    localparam int unsigned IW = $clog2(NUM_BYTES + 64);

    typedef enum logic [0:0] {StIdle, StSend} state_t;

    state_t          state, state_next;
    logic [0:FW-1]   bank0, bank1;
    logic [1:0]      full, full_next;
    logic            wr_sel, rd_sel, rd_sel_next;
    logic            in_reset;
    logic            empty, empty_next;
    logic [IW-1:0]   idx, idx_next;
    logic [IW-1:0]   end_idx, end_idx_next;
    logic [IW-1:0]   head_ext, tail_ext;
    logic            wr_fire, release_bank, load_frame;
    logic [0:FW-1]   rd_bank;
    logic [DW-1:0]   rd_byte;

    assign head_ext = IW'(i_strip_head);
    assign tail_ext = IW'(i_strip_tail);

    // in_reset keeps the input side closed for the cycle(s) rst is applied.
    assign o_parallel_rdy = en & ~in_reset & ~full[wr_sel];
    assign wr_fire        = i_parallel_vld & o_parallel_rdy;
    assign o_busy         = full[0] | full[1];

    // Select the byte at idx from the bank currently being drained.
    always_comb begin
        rd_bank = rd_sel ? bank1 : bank0;
        rd_byte = '0;
        for (int unsigned b = 0; b < NUM_BYTES; b++) begin
            if (idx == IW'(b)) begin
                rd_byte = rd_bank[b*DW +: DW];
            end
        end
    end

    // Next-state logic for the serialiser FSM, bank flags and outputs.
    always_comb begin
        state_next      = state;
        idx_next        = idx;
        end_idx_next    = end_idx;
        empty_next      = empty;
        rd_sel_next     = rd_sel;
        release_bank    = 1'b0;
        load_frame      = 1'b0;
        o_data_dout_vld = 1'b0;
        o_data_dout     = '0;
        o_frame_last    = 1'b0;

        unique case (state)
            StIdle: begin
                if (en && full[rd_sel]) begin
                    load_frame = 1'b1;
                end
            end
            StSend: begin
                o_data_dout_vld = en & ~empty;
                o_data_dout     = empty ? '0 : rd_byte;
                o_frame_last    = ~empty & (idx == end_idx);
                if (en) begin
                    // A fully stripped frame is released without emitting anything.
                    if (empty || (i_data_dout_rdy && idx == end_idx)) begin
                        release_bank = 1'b1;
                    end else if (i_data_dout_rdy) begin
                        idx_next = idx + 1'b1;
                    end
                end
            end
            default: begin
                state_next = StIdle;
            end
        endcase

        // Chain straight into the other bank when it is already full.
        if (release_bank) begin
            rd_sel_next = ~rd_sel;
            if (full[~rd_sel]) begin
                load_frame = 1'b1;
            end else begin
                state_next = StIdle;
            end
        end

        // Strip values are captured at the start of every frame.
        if (load_frame) begin
            state_next   = StSend;
            idx_next     = head_ext;
            end_idx_next = IW'(NUM_BYTES - 1) - tail_ext;
            empty_next   = (head_ext + tail_ext) >= IW'(NUM_BYTES);
        end

        // Release and write always target different banks, so both can apply.
        full_next = full;
        if (release_bank) begin
            full_next[rd_sel] = 1'b0;
        end
        if (wr_fire) begin
            full_next[wr_sel] = 1'b1;
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge dout_clk) begin
        if (rst) begin
            state    <= StIdle;
            full     <= 2'b00;
            wr_sel   <= 1'b0;
            rd_sel   <= 1'b0;
            idx      <= '0;
            end_idx  <= '0;
            empty    <= 1'b0;
            in_reset <= 1'b1;
        end else begin
            state    <= state_next;
            full     <= full_next;
            rd_sel   <= rd_sel_next;
            idx      <= idx_next;
            end_idx  <= end_idx_next;
            empty    <= empty_next;
            in_reset <= 1'b0;
            if (wr_fire) begin
                wr_sel <= ~wr_sel;
            end
        end
    end

    // Bank data needs no reset; the full flags decide whether it is meaningful.
    always_ff @(posedge dout_clk) begin
        if (wr_fire) begin
            if (wr_sel) begin
                bank1 <= parallel_data;
            end else begin
                bank0 <= parallel_data;
            end
        end
    end

endmodule
